// File: rtl/alu_sequencer.sv
// Multi-cycle add/sub/mul/div engine with valid/ready request and response ports.
// Define CALC_DIV_EN to build the restoring divider; otherwise op 3 reports divide-by-zero.
module alu_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             div_zero,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  localparam logic [1:0] OpAdd = 2'd0;
  localparam logic [1:0] OpSub = 2'd1;
  localparam logic [1:0] OpMul = 2'd2;
  localparam logic [1:0] OpDiv = 2'd3;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e               state_q;
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_step;
  logic [CntW-1:0]      cnt_q;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       sub_diff;
  logic [WIDTH:0]       mul_sum;
  logic                 div_by_zero;
`ifdef CALC_DIV_EN
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_trial;
`endif

  // acc_q holds {high half, multiplier} for mul and {remainder, dividend/quotient} for div.
  always_comb begin
    add_sum  = {1'b0, a_q} + {1'b0, b_q};
    sub_diff = {1'b0, a_q} - {1'b0, b_q};
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    acc_step = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef CALC_DIV_EN
    div_by_zero = (b_q == '0);
    div_shift   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial   = div_shift - {1'b0, b_q};
    if (op_q == OpDiv) begin
      // A borrow in the top bit means the trial subtraction must be undone.
      acc_step = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
`else
    div_by_zero = 1'b1;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result   <= '0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q    <= op;
            a_q     <= operand_a;
            b_q     <= operand_b;
            cnt_q   <= '0;
            acc_q   <= {{WIDTH{1'b0}}, (op == OpDiv) ? operand_a : operand_b};
            state_q <= StExec;
          end
        end
        StExec: begin
          unique case (op_q)
            OpAdd: begin
              result   <= add_sum[WIDTH-1:0];
              overflow <= add_sum[WIDTH];
              div_zero <= 1'b0;
              state_q  <= StDone;
            end
            OpSub: begin
              result   <= sub_diff[WIDTH-1:0];
              overflow <= sub_diff[WIDTH];
              div_zero <= 1'b0;
              state_q  <= StDone;
            end
            OpMul, OpDiv: begin
              if (op_q == OpDiv && div_by_zero) begin
                result   <= '1;
                overflow <= 1'b0;
                div_zero <= 1'b1;
                state_q  <= StDone;
              end else begin
                acc_q <= acc_step;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                  result   <= acc_step[WIDTH-1:0];
                  overflow <= (op_q == OpMul) && (|acc_step[2*WIDTH-1:WIDTH]);
                  div_zero <= 1'b0;
                  state_q  <= StDone;
                end
              end
            end
            default: state_q <= StDone;
          endcase
        end
        StDone: begin
          if (rsp_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q == StExec);
  assign rsp_valid = (state_q == StDone);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases plus random transactions vs. a model.
module tb_alu_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] result;
  logic        overflow;
  logic        div_zero;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  alu_sequencer #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .result    (result),
    .overflow  (overflow),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: plain wide arithmetic on the operation's definition.
  function automatic void model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ov, output logic dz,
                                output int lat);
    logic [63:0] wide;
    bit div_en;
`ifdef CALC_DIV_EN
    div_en = 1'b1;
`else
    div_en = 1'b0;
`endif
    dz  = 1'b0;
    ov  = 1'b0;
    lat = 2;
    case (mop)
      2'd0: begin
        wide = {32'd0, a} + {32'd0, b};
        r    = wide[31:0];
        ov   = (wide[63:32] != 32'd0);
      end
      2'd1: begin
        r  = a - b;
        ov = (a < b);
      end
      2'd2: begin
        wide = {32'd0, a} * {32'd0, b};
        r    = wide[31:0];
        ov   = (wide[63:32] != 32'd0);
        lat  = 33;
      end
      default: begin
        if (div_en && b != 32'd0) begin
          r   = a / b;
          lat = 33;
        end else begin
          r  = 32'hFFFF_FFFF;
          dz = 1'b1;
        end
      end
    endcase
  endfunction

  // Issue one request, measure latency, optionally backpressure, then hand-shake the response.
  task automatic run_txn(input string tag, input logic [1:0] t_op, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic        eov, edz;
    int          elat, lat;
    model(t_op, a, b, er, eov, edz, elat);
    req_valid = 1'b1;
    op        = t_op;
    operand_a = a;
    operand_b = b;
    check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    op        = 2'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
    check({tag, " busy"}, 32'(busy), 32'd1);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " result"}, result, er);
    check({tag, " overflow"}, 32'(overflow), 32'(eov));
    check({tag, " div_zero"}, 32'(div_zero), 32'(edz));
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      operand_a = $urandom;
      operand_b = $urandom;
      @(posedge clock); #1;
      check({tag, " held result"}, result, er);
      check({tag, " held req_ready"}, 32'(req_ready), 32'd0);
      check({tag, " held rsp_valid"}, 32'(rsp_valid), 32'd1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    check({tag, " rsp_valid after hs"}, 32'(rsp_valid), 32'd0);
    check({tag, " req_ready after hs"}, 32'(req_ready), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " result"}, result, 32'd0);
    check({tag, " overflow"}, 32'(overflow), 32'd0);
    check({tag, " div_zero"}, 32'(div_zero), 32'd0);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    op        = 2'd0;
    operand_a = 32'd0;
    operand_b = 32'd0;
    #12;
    check_reset_values("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    run_txn("add 7+5", 2'd0, 32'd7, 32'd5, 0);
    run_txn("add wrap", 2'd0, 32'hFFFF_FFFF, 32'd1, 0);
    run_txn("sub 3-5", 2'd1, 32'd3, 32'd5, 0);
    run_txn("sub 9-9", 2'd1, 32'd9, 32'd9, 0);
    run_txn("mul 123*456", 2'd2, 32'd123, 32'd456, 0);
    run_txn("mul ovf", 2'd2, 32'h0001_0000, 32'h0001_0000, 0);
    run_txn("div 100/7", 2'd3, 32'd100, 32'd7, 0);
    run_txn("div 5/0", 2'd3, 32'd5, 32'd0, 0);
    run_txn("mul backpressure", 2'd2, 32'hDEAD_BEEF, 32'd3, 5);

    // Reset in the middle of a multiply.
    req_valid = 1'b1;
    op        = 2'd2;
    operand_a = 32'd1234;
    operand_b = 32'd5678;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("mid-mul reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    run_txn("add 2+2 after reset", 2'd0, 32'd2, 32'd2, 0);

    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      case ($urandom_range(0, 3))
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(1, 15));
        default: r_b = $urandom;
      endcase
      run_txn($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, r_b, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
